serial_word_rx: RTL and testbench
=================================

Name: serial_word_rx

Overview:
- Receiver end of the single-bit serial stream the team drives into the flop-level blocks: one bit per accepted clock on `d`.
- Hunts for a sync word, then deserializes fixed-length frames of WIDTH-bit words, LSB first.
- Presents each word on a one-entry valid/ready output register.
- Sits between a serial link input (retimed by a D flop upstream) and any parallel word consumer.

Parameters:
- WIDTH, 8, bits per data word and per sync word.
- SYNC_WORD, 8'hA5, WIDTH-bit pattern that opens a frame (received LSB first).
- FRAME_WORDS, 4, data words per frame after the sync word; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- d  input  1  serial data bit.
- d_valid  input  1  `d` is sampled only on edges where d_valid=1.
- resync  input  1  synchronous pulse: abort the current frame and return to HUNT.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid=1 and out_ready=1.
- out_perr  output  1  parity error flag qualified by out_valid; constant 0 unless SERDES_RX_PARITY_EN is defined.
- sync_lock  output  1  1 while in LOCKED.
- overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HUNT; shift register, bit_cnt and word_cnt cleared.
  - out_data=0, out_valid=0, out_perr=0, sync_lock=0, overrun=0.
  - Deassertion takes effect at the next clk edge.
- Shift register sr (WIDTH bits), LSB first: on an accepted bit, sr_next = {d, sr[WIDTH-1:1]}.
- HUNT:
  - Each accepted bit shifts.
  - If sr_next == SYNC_WORD: state goes to LOCKED on the same edge; bit_cnt=0, word_cnt=0, sr cleared.
  - sync_lock=1 from the following cycle.
  - A sync match is evaluated on every bit (sliding window, no alignment).
- LOCKED:
  - Each accepted bit shifts and increments bit_cnt.
  - On the accepted bit where bit_cnt==WIDTH-1, the word {d, sr[WIDTH-1:1]} completes; bit_cnt wraps to 0 and word_cnt increments.
  - If the completed word is number FRAME_WORDS-1, state goes to HUNT on the same edge (sync_lock=0 next cycle).
  - Data bits are never compared against SYNC_WORD.
- Output register, evaluated on the edge where a word completes:
  - out_valid=0, or out_valid=1 with out_ready=1: out_data is loaded and out_valid=1 next cycle. Latency is 1 clk from the last bit's edge.
  - out_valid=1 with out_ready=0: the new word is dropped, out_data is unchanged, overrun=1 for exactly one cycle. Frame counting continues.
- Output register, on an edge with no completing word: out_valid=1 with out_ready=1 clears out_valid.
- d_valid=0 cycles: shift register and counters hold; the output handshake still operates.
- resync=1 on an edge:
  - State goes to HUNT; sr, bit_cnt and word_cnt are cleared.
  - Any bit on that edge is discarded, and resync wins over a completing word on the same edge.
  - The pending out_valid/out_data is not affected.
- out_data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SERDES_RX_PARITY_EN.
- When defined:
  - In LOCKED, each data word is followed by one even-parity bit, so a word occupies WIDTH+1 accepted bits.
  - The word completes on the parity bit's edge.
  - out_perr = (XOR of the WIDTH data bits and the parity bit) != 0, loaded alongside out_data.
  - A word with out_perr=1 is still delivered.
  - The sync word carries no parity bit.
- When not defined:
  - No parity bit; words are WIDTH bits.
  - out_perr is tied to 0.

Test Plan:
All scenarios use WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=4, d_valid=1 and out_ready=1 unless stated otherwise.
- Lock and first word: bits 1,0,1,0,0,1,0,1 (A5), then 0,0,1,1,1,1,0,0 (3C) -> sync_lock=1 the cycle after the 8th bit; out_valid=1 with out_data=8'h3C one cycle after the 16th bit; overrun=0.
- No sync: 64 zero bits, then 64 bits of 0xFF -> sync_lock, out_valid and overrun stay 0.
- Backpressure: lock, out_ready=0, send 0x11 then 0x22 -> out_data stays 8'h11; overrun pulses for one cycle after the 0x22 word completes; raising out_ready then clears out_valid on the next edge.
- Frame end and d_valid gaps: lock, send 0x01,0x02,0x03,0x04 with d_valid=0 every third cycle -> four words delivered in order; sync_lock=0 after the 0x04 word; a following 0x5A word is not delivered.
- Resync and reset mid-word: lock, send 5 bits of a word, pulse resync -> sync_lock=0 and no word produced; relock and send 0x77 -> out_data=8'h77. Then assert reset=0 mid-word -> all outputs 0 immediately, asynchronously.
- Parity (SERDES_RX_PARITY_EN defined): lock, send 0x03+parity 0, then 0x03+parity 1 -> out_data=8'h03 twice, with out_perr=0 then 1.

Source files
------------

// File: rtl/serial_word_rx.sv
// serial_word_rx: sync-word hunting serial deserializer feeding a one-entry valid/ready word register.
// Optional per-word even parity bit is enabled by defining SERDES_RX_PARITY_EN.
module serial_word_rx #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
    parameter int FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             d_valid,
    input  logic             resync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             sync_lock,
    output logic             overrun
);

`ifdef SERDES_RX_PARITY_EN
    localparam int WORD_BITS = WIDTH + 1;
`else
    localparam int WORD_BITS = WIDTH;
`endif
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam int WW = $clog2(FRAME_WORDS + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WW-1:0]    word_cnt, word_cnt_nxt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_done;
`ifdef SERDES_RX_PARITY_EN
    logic             word_perr;

    function automatic logic parity_err(input logic [WIDTH-1:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    assign shifted = {d, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            sr       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        word_done    = 1'b0;
        word         = shifted;
`ifdef SERDES_RX_PARITY_EN
        word_perr    = 1'b0;
`endif
        if (resync) begin
            // resync discards the bit on this edge and beats a completing word
            state_nxt    = HUNT;
            sr_nxt       = '0;
            bit_cnt_nxt  = '0;
            word_cnt_nxt = '0;
        end else if (d_valid) begin
            case (state)
                HUNT: begin
                    sr_nxt = shifted;
                    if (shifted == SYNC_WORD) begin
                        state_nxt    = LOCKED;
                        sr_nxt       = '0;
                        bit_cnt_nxt  = '0;
                        word_cnt_nxt = '0;
                    end
                end
                default: begin
`ifdef SERDES_RX_PARITY_EN
                    // parity bit closes the word; the data bits are already in sr
                    if (bit_cnt == BW'(WIDTH)) begin
                        word_done = 1'b1;
                        word      = sr;
                        word_perr = parity_err(sr, d);
                    end else begin
                        sr_nxt = shifted;
                    end
`else
                    sr_nxt = shifted;
                    if (bit_cnt == BW'(WIDTH - 1))
                        word_done = 1'b1;
`endif
                    if (word_done) begin
                        bit_cnt_nxt = '0;
                        if (word_cnt == WW'(FRAME_WORDS - 1)) begin
                            state_nxt    = HUNT;
                            word_cnt_nxt = '0;
                        end else begin
                            word_cnt_nxt = word_cnt + WW'(1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        sync_lock = (state == LOCKED);
    end

    // one-entry output register: a word arriving while the entry is stuck is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            out_perr  <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
`ifdef SERDES_RX_PARITY_EN
                    out_perr  <= word_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef SERDES_RX_PARITY_EN
    assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed plus randomized stimulus against a queue-based frame model of serial_word_rx.
// Exercises the default build (SERDES_RX_PARITY_EN undefined).
module tb_serial_word_rx;

    localparam int W = 8;
    localparam logic [W-1:0] SYNC = 8'hA5;
    localparam int FW = 4;

    logic         clk;
    logic         reset;
    logic         d;
    logic         d_valid;
    logic         resync;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_perr;
    logic         sync_lock;
    logic         overrun;

    serial_word_rx #(.WIDTH(W), .SYNC_WORD(SYNC), .FRAME_WORDS(FW)) dut (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .resync(resync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_perr(out_perr), .sync_lock(sync_lock), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: bit-level view of the link, words as queues of received bits
    bit           m_locked;
    bit           win_q[$];
    bit           wq[$];
    int           m_wcnt;
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_ovr;

    function automatic logic [W-1:0] pack(input bit q[$]);
        logic [W-1:0] r = '0;
        foreach (q[i]) if (i < W) r[i] = q[i];
        return r;
    endfunction

    function automatic logic pick(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic clear_window();
        win_q.delete();
        repeat (W) win_q.push_back(1'b0);
    endtask

    task automatic model_reset();
        m_locked = 0;
        clear_window();
        wq.delete();
        m_wcnt  = 0;
        m_data  = '0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("sync_lock", 32'(sync_lock), 32'(m_locked));
        check("out_perr",  32'(out_perr),  32'd0);
    endtask

    task automatic step(input logic bd, input logic bdv, input logic brs, input logic brdy);
        bit           done;
        logic [W-1:0] wd;
        d = bd; d_valid = bdv; resync = brs; out_ready = brdy;
        @(posedge clk);
        cyc++;
        done = 0;
        wd   = '0;
        if (brs) begin
            m_locked = 0;
            clear_window();
            wq.delete();
            m_wcnt = 0;
        end else if (bdv) begin
            if (!m_locked) begin
                win_q.push_back(bit'(bd));
                void'(win_q.pop_front());
                if (pack(win_q) == SYNC) begin
                    m_locked = 1;
                    clear_window();
                    wq.delete();
                    m_wcnt = 0;
                end
            end else begin
                wq.push_back(bit'(bd));
                if (wq.size() == W) begin
                    done = 1;
                    wd   = pack(wq);
                    m_wcnt++;
                    if (m_wcnt == FW) begin
                        m_locked = 0;
                        m_wcnt   = 0;
                        win_q    = wq;
                    end
                    wq.delete();
                end
            end
        end
        m_ovr = 0;
        if (done) begin
            if (!m_valid || brdy) begin
                m_data  = wd;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && brdy) begin
            m_valid = 0;
        end
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gap3, input int dv_pct, input int rdy_pct);
        for (int i = 0; i < W; i++) begin
            while (int'($urandom_range(99)) >= dv_pct)
                step(1'($urandom_range(1)), 1'b0, 1'b0, pick(rdy_pct));
            if (gap3 && (cyc % 3 == 2))
                step(1'($urandom_range(1)), 1'b0, 1'b0, pick(rdy_pct));
            step(w[i], 1'b1, 1'b0, pick(rdy_pct));
        end
    endtask

    initial begin
        d = 0; d_valid = 0; resync = 0; out_ready = 1;
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #1 check_all();
        @(negedge clk);
        reset = 1'b1;

        // lock and first word
        send_word(SYNC, 0, 100, 100);
        check("lock_after_sync", 32'(sync_lock), 32'd1);
        send_word(8'h3C, 0, 100, 100);
        check("first_word_valid", 32'(out_valid), 32'd1);
        check("first_word_data", 32'(out_data), 32'h3C);
        check("first_word_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < FW - 1; i++) send_word(8'($urandom), 0, 100, 100);

        // no sync in long constant runs
        repeat (64) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (64) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("nosync_lock", 32'(sync_lock), 32'd0);
        check("nosync_valid", 32'(out_valid), 32'd0);

        // backpressure
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(SYNC, 0, 100, 0);
        send_word(8'h11, 0, 100, 0);
        send_word(8'h22, 0, 100, 0);
        check("bp_ovr_pulse", 32'(overrun), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'h11);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_ovr_single", 32'(overrun), 32'd0);
        check("bp_still_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_drain", 32'(out_valid), 32'd0);

        // frame end with d_valid gaps
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(SYNC, 1, 100, 100);
        send_word(8'h01, 1, 100, 100);
        check("frame_w1", 32'(out_data), 32'h01);
        send_word(8'h02, 1, 100, 100);
        check("frame_w2", 32'(out_data), 32'h02);
        send_word(8'h03, 1, 100, 100);
        check("frame_w3", 32'(out_data), 32'h03);
        send_word(8'h04, 1, 100, 100);
        check("frame_w4", 32'(out_data), 32'h04);
        check("frame_unlock", 32'(sync_lock), 32'd0);
        send_word(8'h5A, 1, 100, 100);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("frame_no_extra", 32'(out_valid), 32'd0);
        check("frame_no_extra_data", 32'(out_data), 32'h04);

        // resync mid-word, then relock
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(SYNC, 0, 100, 100);
        for (int i = 0; i < 5; i++) step(1'(i & 1), 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("resync_unlock", 32'(sync_lock), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("resync_no_word", 32'(out_valid), 32'd0);
        send_word(SYNC, 0, 100, 100);
        send_word(8'h77, 0, 100, 100);
        check("relock_word", 32'(out_data), 32'h77);

        // asynchronous reset mid-word
        send_word(8'h5C, 0, 100, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_data", 32'(out_data), 32'd0);
        check("areset_lock", 32'(sync_lock), 32'd0);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) != 0) send_word(SYNC, 0, 80, 70);
            repeat ($urandom_range(1, 6)) send_word(8'($urandom), 0, 75, 60);
            if ($urandom_range(3) == 0)
                step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, pick(50));
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
